// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back data cache controller (optional CACHE_STATS_EN hit/miss counters)
module dcache_controller (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
`ifdef CACHE_STATS_EN
   output logic [15:0] HIT_COUNT,
   output logic [15:0] MISS_COUNT,
`endif
   input  logic        MEM_BUSYWAIT
);
   typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_FETCH, UPDATE} state_t;
   state_t           state_q, state_d;
   logic [7:0][31:0] data_q, data_d;
   logic [7:0][2:0]  tag_q, tag_d;
   logic [7:0]       valid_q, valid_d, dirty_q, dirty_d;
   logic [7:0]       addr_q, addr_d;
   logic             seen_q, seen_d;
   logic [7:0]       a;
   logic [2:0]       idx;
   logic [31:0]      blk;
   logic             req, hit, acc;
   assign req = (READ | WRITE) & ~RESET;
   assign a   = (state_q == IDLE) ? ADDRESS : addr_q;
   assign idx = a[4:2];
   assign blk = data_q[idx];
   assign hit = valid_q[idx] && (tag_q[idx] == a[7:5]);
   assign acc = (state_q == IDLE) && req;
   // next-state, array updates and all combinational outputs
   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      tag_d         = tag_q;
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      addr_d        = addr_q;
      seen_d        = 1'b0;
      READDATA      = '0;
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      case (state_q)
         IDLE: if (req) begin
            addr_d = ADDRESS;
            if (hit) begin
               READDATA = READ ? blk[{ADDRESS[1:0], 3'b000} +: 8] : '0;
               if (WRITE) begin
                  data_d[idx][{ADDRESS[1:0], 3'b000} +: 8] = WRITEDATA;
                  dirty_d[idx] = 1'b1;
               end
            end else begin
               BUSYWAIT = 1'b1;
               state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITE_BACK : MEM_FETCH;
            end
         end
         WRITE_BACK: begin
            BUSYWAIT      = 1'b1;
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {tag_q[idx], idx};
            MEM_WRITEDATA = blk;
            seen_d        = seen_q | MEM_BUSYWAIT;
            if (seen_q && !MEM_BUSYWAIT) begin
               state_d = MEM_FETCH;
               seen_d  = 1'b0;
            end
         end
         MEM_FETCH: begin
            BUSYWAIT    = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = {addr_q[7:5], idx};
            seen_d      = seen_q | MEM_BUSYWAIT;
            if (seen_q && !MEM_BUSYWAIT) begin
               state_d = UPDATE;
               seen_d  = 1'b0;
            end
         end
         UPDATE: begin
            BUSYWAIT     = 1'b1;
            data_d[idx]  = MEM_READDATA;
            tag_d[idx]   = addr_q[7:5];
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end
   // state and cache arrays; reset invalidates every block and drops any dirty data
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         addr_q  <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         addr_q  <= addr_d;
         seen_q  <= seen_d;
      end
      data_q <= data_d;
      tag_q  <= tag_d;
   end
`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic        upd_q, upd_d;
   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;
   // saturating counters; the replayed hit right after a fill is not a new hit
   always_comb begin
      upd_d      = state_q == UPDATE;
      hit_cnt_d  = (acc && hit && !upd_q && hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
      miss_cnt_d = (acc && !hit && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
   end
   // statistics registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         upd_q      <= 1'b0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         upd_q      <= upd_d;
      end
   end
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed self-checking bench for dcache_controller
module tb_dcache_controller;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        READ = 1'b0;
   logic        WRITE = 1'b0;
   logic [7:0]  ADDRESS = '0;
   logic [7:0]  WRITEDATA = '0;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA = '0;
   logic        MEM_BUSYWAIT = 1'b0;
`ifdef CACHE_STATS_EN
   logic [15:0] HIT_COUNT, MISS_COUNT;
`endif
   int tests = 0;
   int fails = 0;

   dcache_controller dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
`ifdef CACHE_STATS_EN
      .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
      .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic hs(input logic [31:0] rd);
      MEM_BUSYWAIT = 1'b1;
      tick();
      MEM_BUSYWAIT = 1'b0;
      MEM_READDATA = rd;
      tick();
   endtask

   initial begin
      tick();
      chk("rst_busy", BUSYWAIT, 0);
      chk("rst_mrd", MEM_READ, 0);
      chk("rst_mwr", MEM_WRITE, 0);
      chk("rst_maddr", MEM_ADDRESS, 0);
      chk("rst_mwdata", MEM_WRITEDATA, 0);
      chk("rst_rdata", READDATA, 0);
      RESET = 1'b0;
      tick();
      // test 1: cold read miss
      READ = 1'b1; ADDRESS = 8'h00; #1;
      chk("t1_busy_miss", BUSYWAIT, 1);
      chk("t1_no_mrd_idle", MEM_READ, 0);
      tick();
      chk("t1_mrd", MEM_READ, 1);
      chk("t1_maddr", MEM_ADDRESS, 6'h00);
      tick();
      chk("t1_hold_no_busy_seen", MEM_READ, 1);
      hs(32'hDDCCBBAA);
      chk("t1_update_mrd", MEM_READ, 0);
      chk("t1_update_busy", BUSYWAIT, 1);
      tick();
      chk("t1_busy_done", BUSYWAIT, 0);
      chk("t1_rdata", READDATA, 8'hAA);
      tick();
      // test 2: read hit
      ADDRESS = 8'h03; #1;
      chk("t2_busy", BUSYWAIT, 0);
      chk("t2_rdata", READDATA, 8'hDD);
      chk("t2_mrd", MEM_READ, 0);
      tick();
      // test 3: write hit then read back
      READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h01; WRITEDATA = 8'h55; #1;
      chk("t3_wr_busy", BUSYWAIT, 0);
      tick();
      WRITE = 1'b0; READ = 1'b1; #1;
      chk("t3_rdata", READDATA, 8'h55);
      tick();
`ifdef CACHE_STATS_EN
      chk("t6_miss_cnt", MISS_COUNT, 16'd1);
      chk("t6_hit_cnt", HIT_COUNT, 16'd3);
`endif
      // test 4: dirty victim write-back then fill
      ADDRESS = 8'h21; #1;
      chk("t4_busy", BUSYWAIT, 1);
      tick();
      chk("t4_mwr", MEM_WRITE, 1);
      chk("t4_mrd_low", MEM_READ, 0);
      chk("t4_wb_addr", MEM_ADDRESS, 6'h00);
      chk("t4_wb_data", MEM_WRITEDATA, 32'hDDCC55AA);
      hs(32'h44332211);
      chk("t4_fetch_mrd", MEM_READ, 1);
      chk("t4_fetch_mwr", MEM_WRITE, 0);
      chk("t4_fetch_addr", MEM_ADDRESS, 6'h08);
      hs(32'h44332211);
      tick();
      chk("t4_busy_done", BUSYWAIT, 0);
      chk("t4_rdata", READDATA, 8'h22);
      tick();
      // READ and WRITE together act as a write
      WRITE = 1'b1; ADDRESS = 8'h22; WRITEDATA = 8'h77; #1;
      chk("rw_busy", BUSYWAIT, 0);
      tick();
      WRITE = 1'b0; #1;
      chk("rw_rdata", READDATA, 8'h77);
      tick();
      ADDRESS = 8'h02; #1;
      chk("rw_miss_busy", BUSYWAIT, 1);
      tick();
      chk("rw_wb_mwr", MEM_WRITE, 1);
      chk("rw_wb_addr", MEM_ADDRESS, 6'h08);
      chk("rw_wb_data", MEM_WRITEDATA, 32'h44772211);
      hs(32'h0);
      chk("rw_fetch_addr", MEM_ADDRESS, 6'h00);
      hs(32'hDDCC55AA);
      tick();
      chk("rw_rdata_refill", READDATA, 8'hCC);
      tick();
      // test 5: reset during fill
      ADDRESS = 8'h1C; #1;
      chk("t5_busy", BUSYWAIT, 1);
      tick();
      chk("t5_mrd", MEM_READ, 1);
      chk("t5_maddr", MEM_ADDRESS, 6'h07);
      RESET = 1'b1; READ = 1'b0;
      tick();
      chk("t5_rst_mrd", MEM_READ, 0);
      chk("t5_rst_busy", BUSYWAIT, 0);
      chk("t5_rst_mwr", MEM_WRITE, 0);
`ifdef CACHE_STATS_EN
      chk("t5_rst_miss_cnt", MISS_COUNT, 16'd0);
      chk("t5_rst_hit_cnt", HIT_COUNT, 16'd0);
`endif
      RESET = 1'b0; READ = 1'b1; ADDRESS = 8'h03; #1;
      chk("t5_miss_after_rst", BUSYWAIT, 1);
      tick();
      chk("t5_fetch_mrd", MEM_READ, 1);
      chk("t5_no_wb", MEM_WRITE, 0);
      chk("t5_fetch_addr", MEM_ADDRESS, 6'h00);
      READ = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
